// File: rtl/digit_entry_pkg.sv
// digit_entry_pkg: shared types and constants for the decimal entry block.
//   state_t  - converter state (IDLE, CONV, FIN)
//   BCD_MAX  - largest legal decimal digit
//   clog2w() - bit width needed to index n items (never less than 1)
package digit_entry_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd2bin_serial.sv
// bcd2bin_serial: serial BCD to binary converter, one digit per cycle, MSD first.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous reset, active-low; aborts a conversion without done
//   start  in   begin a conversion (honoured only while idle)
//   bcd    in   packed BCD digits, digit 0 in bits [3:0]; must stay stable while busy
//   busy   out  high in CONV and FIN
//   done   out  one-cycle pulse when value has just been updated
//   value  out  binary result of the last completed conversion
module bcd2bin_serial
  import digit_entry_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    value
);

  localparam int IDX_W = clog2w(DIGITS);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

  state_t           state;
  logic [BIN_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [3:0]       digit;

  // acc*10 + d, with the multiply built from two shifts
  function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] a,
                                             input logic [3:0]       d);
    return (a << 3) + (a << 1) + BIN_W'(d);
  endfunction

  assign digit = bcd[{idx, 2'b00} +: 4];

  // Control: state, busy, done, value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      value <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CONV;
            busy  <= 1'b1;
          end
        end
        CONV: begin
          if (idx == '0) state <= FIN;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          value <= acc;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: accumulator and digit index. They are re-primed on every idle
  // cycle, so the accumulator is already clear when CONV begins and an
  // aborted conversion leaves nothing behind.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      acc <= '0;
      idx <= IDX_TOP;
    end else if (state == CONV) begin
      acc <= mac10(acc, digit);
      idx <= idx - 1'b1;
    end
  end

endmodule

// File: rtl/digit_entry.sv
// digit_entry: editable DIGITS-digit decimal entry with serial BCD->binary
// conversion for the factorization core.
// Ports:
//   CLK       in   system clock, rising edge
//   RST       in   synchronous reset, active-low
//   SEL_NEXT  in   pulse: cursor one digit toward MSD (wraps to 0)
//   SEL_PREV  in   pulse: cursor one digit toward LSD (wraps to DIGITS-1)
//   INC/DEC   in   pulse: step digit at cursor, 9<->0 wrap, no carry/borrow
//   CLR       in   pulse: all digits and cursor to 0
//   ENTER     in   pulse: start conversion
//   BCD       out  packed digits, digit 0 in [3:0]
//   CURSOR    out  cursor index, 0 = LSD
//   BLANK     out  per-digit blank request (1 = blank)
//   BUSY      out  conversion in progress
//   DONE      out  one-cycle pulse, VALUE just updated
//   VALUE     out  binary result of last conversion
// Build option: define DIGIT_ENTRY_BLINK_EN to blink the digit under the
// cursor with a BLINK_DIV-cycle half period; otherwise BLANK is constant 0.
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int BIN_W     = 20,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SEL_NEXT,
  input  logic                        SEL_PREV,
  input  logic                        INC,
  input  logic                        DEC,
  input  logic                        CLR,
  input  logic                        ENTER,
  output logic [4*DIGITS-1:0]         BCD,
  output logic [clog2w(DIGITS)-1:0]   CURSOR,
  output logic [DIGITS-1:0]           BLANK,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [BIN_W-1:0]            VALUE
);

  localparam int CUR_W = clog2w(DIGITS);
  localparam logic [CUR_W-1:0] CUR_TOP = CUR_W'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] digits;
  logic [CUR_W-1:0]       cursor;
  logic                   idle;
  logic                   enter_req;
  logic                   start;

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_dec(input logic [3:0] d);
    return (d == 4'd0) ? BCD_MAX : d - 4'd1;
  endfunction

  // BUSY spans CONV and FIN. The DONE cycle is already idle for editing, but
  // an ENTER landing there is dropped so the result pulse is never overlapped.
  assign idle      = !BUSY;
  assign enter_req = ENTER && !DONE;
  assign start     = idle && enter_req && !CLR;

  // Edit state: priority CLR > ENTER > SEL > INC/DEC, one action per cycle
  always_ff @(posedge CLK) begin
    if (!RST) begin
      digits <= '0;
      cursor <= '0;
    end else if (idle) begin
      if (CLR) begin
        digits <= '0;
        cursor <= '0;
      end else if (!enter_req) begin
        if (SEL_NEXT || SEL_PREV) begin
          if (SEL_NEXT && !SEL_PREV)
            cursor <= (cursor == CUR_TOP) ? '0 : cursor + 1'b1;
          else if (SEL_PREV && !SEL_NEXT)
            cursor <= (cursor == '0) ? CUR_TOP : cursor - 1'b1;
        end else if (INC && !DEC) begin
          digits[cursor] <= digit_inc(digits[cursor]);
        end else if (DEC && !INC) begin
          digits[cursor] <= digit_dec(digits[cursor]);
        end
      end
    end
  end

  assign BCD    = digits;
  assign CURSOR = cursor;

  bcd2bin_serial #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_conv (
    .clk   (CLK),
    .rst_n (RST),
    .start (start),
    .bcd   (BCD),
    .busy  (BUSY),
    .done  (DONE),
    .value (VALUE)
  );

`ifdef DIGIT_ENTRY_BLINK_EN
  localparam int DIV_W = clog2w(BLINK_DIV);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             phase;
  logic             edit;

  // Any button press while idle restarts the blink with the digit visible
  assign edit = idle && (CLR || ENTER || SEL_NEXT || SEL_PREV || INC || DEC);

  always_ff @(posedge CLK) begin
    if (!RST || BUSY || edit) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_cnt == DIV_TOP) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    BLANK = '0;
    if (idle) BLANK[cursor] = phase;
  end
`else
  // No blinking: BLANK is tied low (a non-positive divider setting, which
  // is meaningless, blanks the whole display instead)
  assign BLANK = {DIGITS{BLINK_DIV < 1}};
`endif

endmodule

// File: tb/tb_digit_entry.sv
`timescale 1ns/1ps
module tb_digit_entry;

  localparam int DIGITS    = 6;
  localparam int BIN_W     = 20;
  localparam int BLINK_DIV = 4;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic                 SEL_NEXT = 1'b0;
  logic                 SEL_PREV = 1'b0;
  logic                 INC = 1'b0;
  logic                 DEC = 1'b0;
  logic                 CLR = 1'b0;
  logic                 ENTER = 1'b0;
  logic [4*DIGITS-1:0]  BCD;
  logic [2:0]           CURSOR;
  logic [DIGITS-1:0]    BLANK;
  logic                 BUSY;
  logic                 DONE;
  logic [BIN_W-1:0]     VALUE;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int mdl_dig[DIGITS];
  int mdl_cur = 0;

  digit_entry #(
    .DIGITS    (DIGITS),
    .BIN_W     (BIN_W),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SEL_NEXT (SEL_NEXT),
    .SEL_PREV (SEL_PREV),
    .INC      (INC),
    .DEC      (DEC),
    .CLR      (CLR),
    .ENTER    (ENTER),
    .BCD      (BCD),
    .CURSOR   (CURSOR),
    .BLANK    (BLANK),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .VALUE    (VALUE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*DIGITS-1:0] mdl_bcd();
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(mdl_dig[i]);
    return r;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < DIGITS; i++) mdl_dig[i] = 0;
    mdl_cur = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle pulse on the chosen buttons, sampled at the next rising edge
  task automatic drive(input logic sn, input logic sp, input logic inc,
                       input logic dec, input logic clr, input logic ent);
    SEL_NEXT = sn; SEL_PREV = sp; INC = inc; DEC = dec; CLR = clr; ENTER = ent;
    tick();
    SEL_NEXT = 0; SEL_PREV = 0; INC = 0; DEC = 0; CLR = 0; ENTER = 0;
  endtask

  // Clear, then dial in n digit by digit from the LSD; cursor ends at 0
  task automatic load_number(input int n);
    int v;
    int d;
    v = n;
    drive(0, 0, 0, 0, 1, 0);
    mdl_clear();
    for (int p = 0; p < DIGITS; p++) begin
      d = v % 10;
      v = v / 10;
      for (int j = 0; j < d; j++) drive(0, 0, 1, 0, 0, 0);
      mdl_dig[p] = d;
      drive(1, 0, 0, 0, 0, 0);
    end
    mdl_cur = 0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    total++; if (BCD !== '0) begin bad++; $display("FAIL reset_bcd: got %h want 0", BCD); end
    total++; if (CURSOR !== 3'd0) begin bad++; $display("FAIL reset_cursor: got %0d want 0", CURSOR); end
    total++; if (VALUE !== '0) begin bad++; $display("FAIL reset_value: got %h want 0", VALUE); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", DONE); end
    total++; if (BLANK !== '0) begin bad++; $display("FAIL reset_blank: got %b want 0", BLANK); end
    RST = 1'b1;
    mdl_clear();
    tick();
  endtask

  task automatic test_inc_dec();
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      mdl_dig[0] = i % 10;
      total++;
      if (BCD !== mdl_bcd()) begin
        bad++; $display("FAIL inc_step%0d: got %h want %h", i, BCD, mdl_bcd());
      end
    end
    drive(0, 0, 0, 1, 0, 0);
    mdl_dig[0] = 9;
    total++; if (BCD !== mdl_bcd()) begin bad++; $display("FAIL dec_wrap: got %h want %h", BCD, mdl_bcd()); end
    drive(0, 0, 1, 1, 0, 0);
    total++; if (BCD !== mdl_bcd()) begin bad++; $display("FAIL inc_dec_both: got %h want %h", BCD, mdl_bcd()); end
    drive(0, 0, 1, 0, 0, 0);
    mdl_dig[0] = 0;
    total++; if (BCD !== mdl_bcd()) begin bad++; $display("FAIL inc_wrap: got %h want %h", BCD, mdl_bcd()); end
  endtask

  task automatic test_cursor();
    drive(0, 1, 0, 0, 0, 0);
    mdl_cur = DIGITS - 1;
    total++; if (CURSOR !== 3'(mdl_cur)) begin bad++; $display("FAIL sel_prev_wrap: got %0d want %0d", CURSOR, mdl_cur); end
    drive(1, 0, 0, 0, 0, 0);
    mdl_cur = 0;
    total++; if (CURSOR !== 3'(mdl_cur)) begin bad++; $display("FAIL sel_next_wrap: got %0d want %0d", CURSOR, mdl_cur); end
    drive(1, 1, 0, 0, 0, 0);
    total++; if (CURSOR !== 3'(mdl_cur)) begin bad++; $display("FAIL sel_both: got %0d want %0d", CURSOR, mdl_cur); end
    // SEL outranks INC: cursor moves, digits untouched
    drive(1, 0, 1, 0, 0, 0);
    mdl_cur = 1;
    total++; if (CURSOR !== 3'(mdl_cur)) begin bad++; $display("FAIL sel_over_inc_cur: got %0d want %0d", CURSOR, mdl_cur); end
    total++; if (BCD !== mdl_bcd()) begin bad++; $display("FAIL sel_over_inc_bcd: got %h want %h", BCD, mdl_bcd()); end
    drive(0, 0, 1, 0, 0, 0);
    mdl_dig[1] = 1;
    total++; if (BCD !== mdl_bcd()) begin bad++; $display("FAIL inc_at_cur1: got %h want %h", BCD, mdl_bcd()); end
  endtask

  task automatic test_convert_123456();
    logic got;
    int   want;
    load_number(123456);
    total++; if (BCD !== 24'h123456) begin bad++; $display("FAIL load_123456: got %h want 123456", BCD); end
    exp_q.push_back(32'h1E240);
    drive(0, 0, 0, 0, 0, 1);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL busy_c0: got %b want 1", BUSY); end
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      if (c == 1) INC = 1'b1;
      if (c == 2) CLR = 1'b1;
      tick();
      INC = 1'b0; CLR = 1'b0;
      if (DONE === 1'b1) begin
        got  = 1'b1;
        want = exp_q.pop_front();
        total++; if (VALUE !== BIN_W'(want)) begin bad++; $display("FAIL value_123456: got %h want %h", VALUE, BIN_W'(want)); end
        total++; if (c != DIGITS + 1) begin bad++; $display("FAIL done_latency: got %0d want %0d", c, DIGITS + 1); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL busy_in_done: got %b want 0", BUSY); end
      end else if (c < DIGITS) begin
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL busy_c%0d: got %b want 1", c, BUSY); end
      end
    end
    total++; if (!got) begin bad++; $display("FAIL done_timeout_123456: got no DONE want DONE"); end
    total++; if (BCD !== 24'h123456) begin bad++; $display("FAIL bcd_kept_busy: got %h want 123456", BCD); end
    tick();
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", DONE); end
  endtask

  task automatic test_convert_999999();
    logic got;
    int   want;
    load_number(999999);
    total++; if (BCD !== 24'h999999) begin bad++; $display("FAIL load_999999: got %h want 999999", BCD); end
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.push_back(999999);
      drive(0, 0, 0, 0, 0, 1);
      got = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
        tick();
        if (DONE === 1'b1) begin
          got  = 1'b1;
          want = exp_q.pop_front();
          total++; if (VALUE !== BIN_W'(want)) begin bad++; $display("FAIL value_999999_p%0d: got %0d want %0d", pass, VALUE, want); end
        end
      end
      total++; if (!got) begin bad++; $display("FAIL done_timeout_999999_p%0d: got no DONE want DONE", pass); end
      if (pass == 0) begin
        // ENTER in the DONE cycle must be dropped
        drive(0, 0, 0, 0, 0, 1);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL enter_in_done: got BUSY=%b want 0", BUSY); end
      end
    end
  endtask

  task automatic test_clr_enter();
    logic seen;
    drive(0, 0, 0, 0, 1, 1);
    mdl_clear();
    total++; if (BCD !== mdl_bcd()) begin bad++; $display("FAIL clr_enter_bcd: got %h want %h", BCD, mdl_bcd()); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL clr_enter_busy: got %b want 0", BUSY); end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (DONE !== 1'b0 || BUSY !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL clr_enter_noconv: got activity=1 want 0"); end
  endtask

  task automatic test_reset_mid_conv();
    logic seen;
    load_number(4321);
    exp_q.push_back(4321);
    drive(0, 0, 0, 0, 0, 1);
    repeat (2) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    void'(exp_q.pop_front());
    mdl_clear();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_conv_busy: got %b want 0", BUSY); end
    total++; if (VALUE !== '0) begin bad++; $display("FAIL rst_conv_value: got %h want 0", VALUE); end
    total++; if (BCD !== mdl_bcd()) begin bad++; $display("FAIL rst_conv_bcd: got %h want %h", BCD, mdl_bcd()); end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (DONE !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rst_conv_done: got DONE=1 want 0"); end
    drive(0, 0, 1, 0, 0, 0);
    mdl_dig[0] = 1;
    total++; if (BCD !== mdl_bcd()) begin bad++; $display("FAIL rst_conv_idle_edit: got %h want %h", BCD, mdl_bcd()); end
  endtask

`ifdef DIGIT_ENTRY_BLINK_EN
  task automatic test_blink();
    logic [DIGITS-1:0] want;
    drive(0, 0, 1, 0, 0, 0);
    mdl_dig[mdl_cur] = (mdl_dig[mdl_cur] + 1) % 10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      want = '0;
      if (c >= 4 && c < 8) want[mdl_cur] = 1'b1;
      total++; if (BLANK !== want) begin bad++; $display("FAIL blink_c%0d: got %b want %b", c, BLANK, want); end
    end
    repeat (4) tick();
    drive(0, 0, 1, 0, 0, 0);
    mdl_dig[mdl_cur] = (mdl_dig[mdl_cur] + 1) % 10;
    total++; if (BLANK !== '0) begin bad++; $display("FAIL blink_inc_show: got %b want 0", BLANK); end
    drive(1, 0, 0, 0, 0, 0);
    mdl_cur = mdl_cur + 1;
    repeat (4) tick();
    want = '0;
    want[mdl_cur] = 1'b1;
    total++; if (BLANK !== want) begin bad++; $display("FAIL blink_cursor1: got %b want %b", BLANK, want); end
  endtask
`else
  task automatic test_blank_off();
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (BLANK !== '0) begin bad++; $display("FAIL blank_off_c%0d: got %b want 0", c, BLANK); end
    end
  endtask
`endif

  initial begin
    mdl_clear();
    test_reset();
    test_inc_dec();
    test_cursor();
    test_convert_123456();
    test_convert_999999();
    test_clr_enter();
    test_reset_mid_conv();
`ifdef DIGIT_ENTRY_BLINK_EN
    test_blink();
`else
    test_blank_off();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
